// File: rtl/si_frame_master.sv
// rtl/si_frame_master.sv - byte-stream to si_* register write-strobe frame master
// Assembles ADDR then DATA bytes MSB first and issues one write strobe per frame.
module si_frame_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_ack,
  output logic [ADDR_WIDTH-1:0] si_addr,
  output logic [DATA_WIDTH-1:0] si_data,
  output logic                  si_rdy,
  input  logic                  si_ack,
  output logic                  err_unmapped,
  output logic                  err_timeout,
  output logic                  busy
);

  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_ADDR, RX_DATA, ISSUE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  timer;
  logic              accept;

  assign rx_ack = rx_rdy & ((state == RX_ADDR) || (state == RX_DATA));
  assign accept = rx_rdy & rx_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RX_ADDR;
      cnt          <= '0;
      timer        <= '0;
      si_addr      <= '0;
      si_data      <= '0;
      si_rdy       <= 1'b0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      si_rdy       <= 1'b0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        RX_ADDR, RX_DATA: begin
          if (accept) begin
            // An accepted byte always beats a simultaneous timer expiry.
            timer <= '0;
            busy  <= 1'b1;
            if (state == RX_ADDR) begin
              si_addr <= (si_addr << 8) | ADDR_WIDTH'(rx_data);
              if (cnt == ADDR_LAST) begin
                cnt   <= '0;
                state <= RX_DATA;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              si_data <= (si_data << 8) | DATA_WIDTH'(rx_data);
              if (cnt == DATA_LAST) begin
                cnt    <= '0;
                state  <= ISSUE;
                si_rdy <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end else if (busy) begin
            if (timer == TMR_MAX) begin
              state       <= RX_ADDR;
              cnt         <= '0;
              timer       <= '0;
              busy        <= 1'b0;
              err_timeout <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ISSUE: begin
          err_unmapped <= ~si_ack;
          state        <= RX_ADDR;
          cnt          <= '0;
          timer        <= '0;
          busy         <= 1'b0;
        end
        default: state <= RX_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_si_frame_master.sv
// tb/tb_si_frame_master.sv - scoreboard bench for si_frame_master
// Stimulus pushes expected frames; a negedge monitor pops and compares on each strobe.
module tb_si_frame_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        rx_ack;
  logic [15:0] si_addr;
  logic [15:0] si_data;
  logic        si_rdy;
  logic        si_ack;
  logic        err_unmapped;
  logic        err_timeout;
  logic        busy;

  always #5 clk = ~clk;

  si_frame_master #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
    .si_addr(si_addr), .si_data(si_data), .si_rdy(si_rdy), .si_ack(si_ack),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout), .busy(busy)
  );

  // Register slaves live at 0x000A, 0x000B and 0x0102 only.
  assign si_ack = si_rdy & ((si_addr == 16'h000A) || (si_addr == 16'h000B) ||
                            (si_addr == 16'h0102));

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        unm;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_to  = 0;
  logic pend     = 1'b0;
  logic pend_unm = 1'b0;
  logic prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (pend) begin
        chk("err_unmapped", {31'b0, err_unmapped}, {31'b0, pend_unm});
        pend = 1'b0;
      end else if (err_unmapped) begin
        chk("spurious_err_unmapped", {31'b0, err_unmapped}, 32'd0);
      end
      if (si_rdy) begin
        if (prev_rdy) chk("si_rdy_consecutive", {31'b0, prev_rdy}, 32'd0);
        chk("busy_in_issue", {31'b0, busy}, 32'd1);
        chk("rx_ack_in_issue", {31'b0, rx_ack}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("si_addr", {16'b0, si_addr}, {16'b0, e.a});
          chk("si_data", {16'b0, si_data}, {16'b0, e.d});
          pend     = 1'b1;
          pend_unm = e.unm;
        end
      end
      prev_rdy = si_rdy;
      if (err_timeout) begin
        chk("err_timeout_expected", {31'b0, exp_to > 0}, 32'd1);
        if (exp_to > 0) exp_to--;
      end
    end else begin
      pend     = 1'b0;
      prev_rdy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    #1;
    while (!rx_ack && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!rx_ack) chk("rx_ack_wait_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_rdy = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] d, input logic unm);
    exp_t e;
    e.a = a; e.d = d; e.unm = unm;
    sb.push_back(e);
    send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(d[15:8]); send_byte(d[7:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_addr",  {16'b0, si_addr}, 32'd0);
    chk("reset_data",  {16'b0, si_data}, 32'd0);
    chk("reset_rdy",   {31'b0, si_rdy}, 32'd0);
    chk("reset_busy",  {31'b0, busy}, 32'd0);
    chk("reset_errs",  {30'b0, err_unmapped, err_timeout}, 32'd0);
    rst = 1'b1;

    // Basic mapped write
    send_frame(16'h000A, 16'h1234, 1'b0);
    idle(3);
    // Unmapped write
    send_frame(16'h00FF, 16'h5555, 1'b1);
    idle(3);

    // Partial frame timeout
    send_byte(8'h00); send_byte(8'h0A);
    #1 chk("busy_mid_frame", {31'b0, busy}, 32'd1);
    exp_to = 1;
    idle(20);
    chk("busy_after_timeout", {31'b0, busy}, 32'd0);
    chk("timeout_seen", exp_to, 32'd0);
    send_frame(16'h000B, 16'h0001, 1'b0);
    idle(3);

    // Each byte lands exactly on the expiry cycle
    begin
      exp_t e;
      e.a = 16'h0102; e.d = 16'h1234; e.unm = 1'b0;
      sb.push_back(e);
      send_byte(8'h01); idle(7);
      send_byte(8'h02); idle(7);
      send_byte(8'h12); idle(7);
      send_byte(8'h34);
    end
    idle(3);

    // rx_rdy held high across two frames
    send_frame(16'h000A, 16'h5A5A, 1'b0);
    send_frame(16'h0102, 16'hBEEF, 1'b0);
    idle(3);

    // Async reset mid-frame
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    #2 rst = 1'b0;
    #1;
    chk("midreset_addr", {16'b0, si_addr}, 32'd0);
    chk("midreset_data", {16'b0, si_data}, 32'd0);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rx_rdy = 1'b0;
    rst = 1'b1;
    send_frame(16'h000B, 16'h0042, 1'b0);
    idle(10);

    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("timeouts_consumed", exp_to, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
